// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the EX/MEM result stage: state encoding, default
// widths and the layout of a buffered entry.
package alu_result_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  // Entry layout, MSB first: {s, zero, overflow, negative, rd, reg_write}
  function automatic int entry_width(input int data_w, input int reg_w);
    return data_w + reg_w + 4;
  endfunction

  function automatic logic is_trap(input logic overflow, input logic sign,
                                   input logic trap_en);
    return overflow && sign && trap_en;
  endfunction

endpackage

// File: rtl/alu_result_stage_skid_fifo2.sv
// Generic two-entry synchronous FIFO with occupancy count and clear.
// Head data is read straight from the storage registers.
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Overflow/underflow requests are ignored so a misbehaving caller cannot
  // corrupt the pointers.
  assign do_push = push && (count_q != 2'd2) && !clear;
  assign do_pop  = pop  && (count_q != 2'd0) && !clear;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (do_push && (wr_ptr_q == gi[0])) mem_d[gi] = din;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q[gi] <= '0;
        else        mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// EX/MEM boundary stage: buffers ALU results and flags in a 2-entry FIFO and
// raises a precise signed-overflow exception held until acknowledged.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_s,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic              in_negative,
  input  logic              in_sign,
  input  logic              in_trap_en,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              out_negative,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              exc_req,
  output logic [DATA_W-1:0] exc_pc,
  input  logic              exc_ack,
  input  logic              flush
);

  localparam int ENTRY_W = entry_width(DATA_W, REG_W);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  exc_pc_q, exc_pc_d;
  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               trap;
  logic               accept;
  logic               push;
  logic               pop;

  assign trap   = is_trap(in_overflow, in_sign, in_trap_en);
  // in_ready depends only on registered occupancy and state.
  assign in_ready = (fifo_count != 2'd2) && (state_q == RUN);
  assign accept = in_valid && in_ready;
  assign push   = accept && !flush;
  assign pop    = out_valid && out_ready;

  // A trapping beat keeps its flags but must never write back.
  assign push_entry = {in_s, in_zero, in_overflow, in_negative, in_rd,
                       in_reg_write && !trap};

  skid_fifo2 #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign {out_s, out_zero, out_overflow, out_negative, out_rd, out_reg_write} = head_entry;

  always_comb begin
    state_d  = state_q;
    exc_pc_d = exc_pc_q;
    if (flush) begin
      // exc_pc deliberately survives a flush for post-mortem inspection.
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (accept && trap) begin
            state_d  = TRAP;
            exc_pc_d = in_pc;
          end
        end
        TRAP: begin
          if (exc_ack) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      exc_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      exc_pc_q <= exc_pc_d;
    end
  end

  assign exc_req = (state_q == TRAP);
  assign exc_pc  = exc_pc_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage with hand-computed
// expectations; one line per checked transaction.
module tb_alu_result_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_s;
  logic        in_zero;
  logic        in_overflow;
  logic        in_negative;
  logic        in_sign;
  logic        in_trap_en;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_zero;
  logic        out_overflow;
  logic        out_negative;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        exc_ack;
  logic        flush;

  int checks = 0;
  int errors = 0;

  alu_result_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_s         (in_s),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .in_negative  (in_negative),
    .in_sign      (in_sign),
    .in_trap_en   (in_trap_en),
    .in_pc        (in_pc),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_s        (out_s),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_negative (out_negative),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .exc_req      (exc_req),
    .exc_pc       (exc_pc),
    .exc_ack      (exc_ack),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] s, input logic ovf, input logic sign,
                      input logic ten, input logic [31:0] pc, input logic [4:0] rd,
                      input logic rw);
    in_valid     = 1'b1;
    in_s         = s;
    in_zero      = (s == 32'd0);
    in_overflow  = ovf;
    in_negative  = s[31];
    in_sign      = sign;
    in_trap_en   = ten;
    in_pc        = pc;
    in_rd        = rd;
    in_reg_write = rw;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_s = '0; in_zero = 1'b0; in_overflow = 1'b0;
    in_negative = 1'b0; in_sign = 1'b0; in_trap_en = 1'b0; in_pc = '0; in_rd = '0;
    in_reg_write = 1'b0; out_ready = 1'b0; exc_ack = 1'b0; flush = 1'b0;

    #12;
    $display("reset: in_ready=%b out_valid=%b exc_req=%b", in_ready, out_valid, exc_req);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exc_req", exc_req, 0);
    chk("rst_exc_pc", exc_pc, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_out_reg_write", out_reg_write, 0);
    reset = 1'b1;
    step();

    // 1: single beat, one-cycle latency
    beat(32'h5, 0, 1, 1, 32'h0040_0000, 5'd3, 1);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    $display("t1 beat: out_valid=%b out_s=%h out_rd=%0d", out_valid, out_s, out_rd);
    chk("t1_valid", out_valid, 1);
    chk("t1_s", out_s, 32'h5);
    chk("t1_rd", out_rd, 3);
    chk("t1_rw", out_reg_write, 1);
    step();
    chk("t1_drained", out_valid, 0);

    // 2: fill, back-pressure, drain in order
    out_ready = 1'b0;
    beat(32'h1, 0, 0, 0, 32'h0, 5'd1, 1);
    step();
    beat(32'h2, 0, 0, 0, 32'h0, 5'd2, 1);
    chk("t2_ready_cnt1", in_ready, 1);
    step();
    beat(32'h3, 0, 0, 0, 32'h0, 5'd3, 1);
    chk("t2_ready_full", in_ready, 0);
    step();
    $display("t2 full: in_ready=%b out_s=%h", in_ready, out_s);
    chk("t2_hold_s", out_s, 32'h1);
    chk("t2_still_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    $display("t2 pop1: out_s=%h in_ready=%b", out_s, in_ready);
    chk("t2_second", out_s, 32'h2);
    chk("t2_ready_after_pop", in_ready, 1);
    step();
    in_valid = 1'b0;
    $display("t2 pop2: out_s=%h out_valid=%b", out_s, out_valid);
    chk("t2_third", out_s, 32'h3);
    chk("t2_third_valid", out_valid, 1);
    step();
    chk("t2_empty", out_valid, 0);

    // 3: signed overflow trap
    out_ready = 1'b0;
    beat(32'h8000_0000, 1, 1, 1, 32'h0040_0010, 5'd8, 1);
    step();
    in_valid = 1'b0;
    $display("t3 trap: rw=%b ovf=%b exc_req=%b exc_pc=%h", out_reg_write, out_overflow, exc_req, exc_pc);
    chk("t3_valid", out_valid, 1);
    chk("t3_rw_masked", out_reg_write, 0);
    chk("t3_ovf", out_overflow, 1);
    chk("t3_rd", out_rd, 8);
    chk("t3_exc_req", exc_req, 1);
    chk("t3_exc_pc", exc_pc, 32'h0040_0010);
    chk("t3_in_ready", in_ready, 0);
    step();
    chk("t3_exc_held", exc_req, 1);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    $display("t3 ack: exc_req=%b in_ready=%b", exc_req, in_ready);
    chk("t3_exc_cleared", exc_req, 0);
    chk("t3_ready_back", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("t3_drained", out_valid, 0);

    // 4: unsigned overflow passes through
    beat(32'hFFFF_FFFE, 1, 0, 1, 32'h0040_0020, 5'd4, 1);
    step();
    in_valid = 1'b0;
    $display("t4 unsigned: exc_req=%b rw=%b ovf=%b", exc_req, out_reg_write, out_overflow);
    chk("t4_no_exc", exc_req, 0);
    chk("t4_rw", out_reg_write, 1);
    chk("t4_ovf", out_overflow, 1);
    chk("t4_s", out_s, 32'hFFFF_FFFE);
    chk("t4_exc_pc_kept", exc_pc, 32'h0040_0010);
    step();

    // 5: flush in TRAP with count=2, concurrent accept and ack
    out_ready = 1'b0;
    beat(32'hA, 0, 1, 1, 32'h0000_00F0, 5'd10, 1);
    step();
    beat(32'hB, 1, 1, 1, 32'h0000_0100, 5'd11, 1);
    step();
    chk("t5_trap_full", exc_req, 1);
    chk("t5_in_ready", in_ready, 0);
    beat(32'hC, 0, 0, 0, 32'h0000_0104, 5'd12, 1);
    flush = 1'b1;
    exc_ack = 1'b1;
    step();
    flush = 1'b0; exc_ack = 1'b0; in_valid = 1'b0;
    $display("t5 flush: out_valid=%b exc_req=%b in_ready=%b exc_pc=%h", out_valid, exc_req, in_ready, exc_pc);
    chk("t5_valid", out_valid, 0);
    chk("t5_exc_req", exc_req, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_exc_pc_kept", exc_pc, 32'h0000_0100);
    step();
    chk("t5_dropped", out_valid, 0);

    // 6: async reset mid-cycle
    beat(32'hD, 1, 1, 1, 32'h0000_0200, 5'd13, 1);
    step();
    in_valid = 1'b0;
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_exc", exc_req, 1);
    #2;
    reset = 1'b0;
    #1;
    $display("t6 async reset: out_valid=%b exc_req=%b exc_pc=%h", out_valid, exc_req, exc_pc);
    chk("t6_valid", out_valid, 0);
    chk("t6_exc", exc_req, 0);
    chk("t6_exc_pc", exc_pc, 0);
    chk("t6_ready", in_ready, 1);
    #3;
    reset = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
